// File: rtl/sblk_row_feeder.sv
// sblk_row_feeder: transmit-side feeder for the superblock row array.
// Routes a row-tagged upstream activation stream into per-row FIFOs that drive
// each row's vld/req handshake, and broadcasts masked instructions to rows
// once every selected row reports idle.
// Optional feature macro: SBLK_FEEDER_CNT_EN builds per-row 16-bit transfer
// counters on act_cnt; without it act_cnt is tied to zero.
module sblk_row_feeder #(
    parameter int N_ROW      = 6,
    parameter int WID_ACT    = 16,
    parameter int WID_INST   = 14,
    parameter int FIFO_DEPTH = 4,
    parameter int INST_GAP   = 2,
    parameter int WID_ROW    = $clog2(N_ROW)
) (
    input  logic                          clk_l,
    input  logic                          rst_n,
    input  logic [2*WID_ACT-1:0]          act_in,
    input  logic [WID_ROW-1:0]            act_in_row,
    input  logic                          act_in_vld,
    output logic                          act_in_rdy,
    input  logic [WID_INST-1:0]           inst_in,
    input  logic [N_ROW-1:0]              inst_in_mask,
    input  logic                          inst_in_vld,
    output logic                          inst_in_rdy,
    output logic [2*WID_ACT*N_ROW-1:0]    act_data_in,
    output logic [N_ROW-1:0]              act_data_in_vld,
    input  logic [N_ROW-1:0]              act_data_in_req,
    output logic [WID_INST*N_ROW-1:0]     inst_data,
    output logic [N_ROW-1:0]              inst_en,
    input  logic [N_ROW-1:0]              status_sblk,
    output logic                          row_err,
    output logic [16*N_ROW-1:0]           act_cnt
);

    localparam int WORD_W   = 2 * WID_ACT;
    localparam int PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W    = $clog2(FIFO_DEPTH + 1);
    localparam int ROW_SPAN = 1 << WID_ROW;
    localparam int GAP_W    = (INST_GAP > 1) ? $clog2(INST_GAP) : 1;

    localparam logic [CNT_W-1:0]   FULL_CNT  = CNT_W'(FIFO_DEPTH);
    localparam logic [WID_ROW:0]   N_ROW_EXT = (WID_ROW + 1)'(N_ROW);
    localparam logic [GAP_W-1:0]   GAP_LAST  = GAP_W'(INST_GAP - 1);

    // ------------------------------------------------------------------
    // Activation path
    // ------------------------------------------------------------------
    logic                 row_in_range;
    logic [N_ROW-1:0]     full_w;
    logic [ROW_SPAN-1:0]  full_pad;
    logic                 row_err_q;

    assign row_in_range = ({1'b0, act_in_row} < N_ROW_EXT);

    // Pad the full flags out to the full tag range so any tag value indexes safely.
    always_comb begin
        full_pad             = '0;
        full_pad[N_ROW-1:0]  = full_w;
    end

    // Out-of-range tags are always accepted (and dropped); a full FIFO refuses
    // even when it pops on the same edge, so rdy depends only on registered state.
    assign act_in_rdy = !row_in_range || !full_pad[act_in_row];

    genvar gi;
    generate
        for (gi = 0; gi < N_ROW; gi++) begin : g_row
            localparam logic [WID_ROW-1:0] ROW_ID = WID_ROW'(gi);

            logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
            logic [PTR_W-1:0]  wr_ptr_q;
            logic [PTR_W-1:0]  rd_ptr_q;
            logic [CNT_W-1:0]  cnt_q;
            logic [CNT_W-1:0]  cnt_d;
            logic              push;
            logic              pop;

            assign push = act_in_vld && row_in_range && (act_in_row == ROW_ID) && !full_w[gi];
            assign pop  = (cnt_q != '0) && act_data_in_req[gi];

            // Occupancy next-state: a simultaneous push and pop leaves it unchanged.
            always_comb begin
                cnt_d = cnt_q;
                if (push && !pop) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else if (pop && !push) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            // FIFO storage, pointers and occupancy; reset flushes contents to zero.
            always_ff @(posedge clk_l or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < FIFO_DEPTH; i++) begin
                        mem_q[i] <= '0;
                    end
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                    cnt_q    <= '0;
                end else begin
                    if (push) begin
                        mem_q[wr_ptr_q] <= act_in;
                        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
                    end
                    if (pop) begin
                        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                    end
                    cnt_q <= cnt_d;
                end
            end

            assign full_w[gi]                        = (cnt_q == FULL_CNT);
            assign act_data_in_vld[gi]               = (cnt_q != '0);
            assign act_data_in[gi*WORD_W +: WORD_W]  = mem_q[rd_ptr_q];

`ifdef SBLK_FEEDER_CNT_EN
            logic [15:0] xfer_cnt_q;

            // Count completed vld&req transfers; wraps naturally at 16 bits.
            always_ff @(posedge clk_l or negedge rst_n) begin
                if (!rst_n) begin
                    xfer_cnt_q <= '0;
                end else if (pop) begin
                    xfer_cnt_q <= xfer_cnt_q + 16'd1;
                end
            end

            assign act_cnt[gi*16 +: 16] = xfer_cnt_q;
`else
            assign act_cnt[gi*16 +: 16] = 16'd0;
`endif
        end
    endgenerate

    // Sticky error for any valid word carrying an out-of-range row tag.
    always_ff @(posedge clk_l or negedge rst_n) begin
        if (!rst_n) begin
            row_err_q <= 1'b0;
        end else if (act_in_vld && !row_in_range) begin
            row_err_q <= 1'b1;
        end
    end

    assign row_err = row_err_q;

    // ------------------------------------------------------------------
    // Instruction broadcast FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ISSUE = 2'd2,
        ST_BLANK = 2'd3
    } inst_state_t;

    inst_state_t               state_q, state_d;
    logic [WID_INST-1:0]       inst_q, inst_d;
    logic [N_ROW-1:0]          mask_q, mask_d;
    logic [GAP_W-1:0]          gap_q, gap_d;
    logic [N_ROW-1:0]          inst_en_q, inst_en_d;
    logic [WID_INST*N_ROW-1:0] inst_data_q, inst_data_d;
    logic                      inst_rdy_q, inst_rdy_d;

    // State register plus the registered instruction outputs.
    always_ff @(posedge clk_l or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            inst_q      <= '0;
            mask_q      <= '0;
            gap_q       <= '0;
            inst_en_q   <= '0;
            inst_data_q <= '0;
            inst_rdy_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            inst_q      <= inst_d;
            mask_q      <= mask_d;
            gap_q       <= gap_d;
            inst_en_q   <= inst_en_d;
            inst_data_q <= inst_data_d;
            inst_rdy_q  <= inst_rdy_d;
        end
    end

    // Next-state: latch in IDLE, wait for selected rows idle, one issue cycle,
    // then a blanking window so the rows' busy status has time to rise.
    always_comb begin
        state_d = state_q;
        inst_d  = inst_q;
        mask_d  = mask_q;
        gap_d   = gap_q;
        case (state_q)
            ST_IDLE: begin
                if (inst_in_vld) begin
                    inst_d = inst_in;
                    mask_d = inst_in_mask;
                    if (|inst_in_mask) begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!(|(status_sblk & mask_q))) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_BLANK;
                gap_d   = '0;
            end
            ST_BLANK: begin
                if (gap_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output next-values keyed on the upcoming state so they appear registered
    // in the same cycle the FSM occupies that state.
    always_comb begin
        inst_en_d   = '0;
        inst_data_d = inst_data_q;
        inst_rdy_d  = (state_d == ST_IDLE);
        if (state_d == ST_ISSUE) begin
            inst_en_d = mask_q;
            for (int r = 0; r < N_ROW; r++) begin
                if (mask_q[r]) begin
                    inst_data_d[r*WID_INST +: WID_INST] = inst_q;
                end
            end
        end
    end

    assign inst_en     = inst_en_q;
    assign inst_data   = inst_data_q;
    assign inst_in_rdy = inst_rdy_q;

endmodule

// File: tb/tb_sblk_row_feeder.sv
// Self-checking bench for sblk_row_feeder: table-driven FIFO vectors followed
// by hand-written stream, instruction and mid-operation reset sequences.
module tb_sblk_row_feeder;

    localparam int N_ROW    = 6;
    localparam int WID_ACT  = 16;
    localparam int WID_INST = 14;
    localparam int INST_GAP = 2;
    localparam int WID_ROW  = 3;

    logic                        clk_l;
    logic                        rst_n;
    logic [2*WID_ACT-1:0]        act_in;
    logic [WID_ROW-1:0]          act_in_row;
    logic                        act_in_vld;
    logic                        act_in_rdy;
    logic [WID_INST-1:0]         inst_in;
    logic [N_ROW-1:0]            inst_in_mask;
    logic                        inst_in_vld;
    logic                        inst_in_rdy;
    logic [2*WID_ACT*N_ROW-1:0]  act_data_in;
    logic [N_ROW-1:0]            act_data_in_vld;
    logic [N_ROW-1:0]            act_data_in_req;
    logic [WID_INST*N_ROW-1:0]   inst_data;
    logic [N_ROW-1:0]            inst_en;
    logic [N_ROW-1:0]            status_sblk;
    logic                        row_err;
    logic [16*N_ROW-1:0]         act_cnt;

    sblk_row_feeder dut (
        .clk_l           (clk_l),
        .rst_n           (rst_n),
        .act_in          (act_in),
        .act_in_row      (act_in_row),
        .act_in_vld      (act_in_vld),
        .act_in_rdy      (act_in_rdy),
        .inst_in         (inst_in),
        .inst_in_mask    (inst_in_mask),
        .inst_in_vld     (inst_in_vld),
        .inst_in_rdy     (inst_in_rdy),
        .act_data_in     (act_data_in),
        .act_data_in_vld (act_data_in_vld),
        .act_data_in_req (act_data_in_req),
        .inst_data       (inst_data),
        .inst_en         (inst_en),
        .status_sblk     (status_sblk),
        .row_err         (row_err),
        .act_cnt         (act_cnt)
    );

    initial clk_l = 1'b0;
    always #5 clk_l = ~clk_l;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic cyc();
        @(posedge clk_l);
        #1;
    endtask

    typedef struct {
        logic [2:0]  row;
        logic [31:0] word;
        logic        vld;
        logic [5:0]  req;
        logic        exp_rdy;
        logic [5:0]  exp_vld;
        logic        chk_head;
        logic [31:0] exp_head2;
        logic        exp_err;
    } vec_t;

    localparam int N_TBL = 16;
    vec_t tbl [N_TBL];

    function automatic logic [13:0] islice(input logic [WID_INST*N_ROW-1:0] v, input int r);
        return v[r*WID_INST +: WID_INST];
    endfunction

    initial begin
        // row, word, vld, req, exp_rdy, exp_vld, chk_head, exp_head2, exp_err
        tbl[0]  = '{3'd2, 32'hA1, 1'b1, 6'b000000, 1'b1, 6'b000100, 1'b1, 32'hA1, 1'b0};
        tbl[1]  = '{3'd2, 32'hA2, 1'b1, 6'b000000, 1'b1, 6'b000100, 1'b1, 32'hA1, 1'b0};
        tbl[2]  = '{3'd2, 32'hA3, 1'b1, 6'b000000, 1'b1, 6'b000100, 1'b1, 32'hA1, 1'b0};
        tbl[3]  = '{3'd2, 32'hA4, 1'b1, 6'b000000, 1'b1, 6'b000100, 1'b1, 32'hA1, 1'b0};
        tbl[4]  = '{3'd3, 32'hB1, 1'b1, 6'b000000, 1'b1, 6'b001100, 1'b1, 32'hA1, 1'b0};
        tbl[5]  = '{3'd2, 32'hA5, 1'b1, 6'b000000, 1'b0, 6'b001100, 1'b1, 32'hA1, 1'b0};
        tbl[6]  = '{3'd2, 32'hA5, 1'b1, 6'b000100, 1'b0, 6'b001100, 1'b1, 32'hA2, 1'b0};
        tbl[7]  = '{3'd2, 32'hA6, 1'b1, 6'b000000, 1'b1, 6'b001100, 1'b1, 32'hA2, 1'b0};
        tbl[8]  = '{3'd7, 32'hE7, 1'b1, 6'b000000, 1'b1, 6'b001100, 1'b1, 32'hA2, 1'b1};
        tbl[9]  = '{3'd6, 32'hE6, 1'b1, 6'b000000, 1'b1, 6'b001100, 1'b1, 32'hA2, 1'b1};
        tbl[10] = '{3'd0, 32'h00, 1'b0, 6'b001100, 1'b1, 6'b000100, 1'b1, 32'hA3, 1'b1};
        tbl[11] = '{3'd0, 32'h00, 1'b0, 6'b000100, 1'b1, 6'b000100, 1'b1, 32'hA4, 1'b1};
        tbl[12] = '{3'd0, 32'h00, 1'b0, 6'b000100, 1'b1, 6'b000100, 1'b1, 32'hA6, 1'b1};
        tbl[13] = '{3'd0, 32'h00, 1'b0, 6'b000100, 1'b1, 6'b000000, 1'b0, 32'h00, 1'b1};
        tbl[14] = '{3'd2, 32'hA7, 1'b1, 6'b000100, 1'b1, 6'b000100, 1'b1, 32'hA7, 1'b1};
        tbl[15] = '{3'd0, 32'h00, 1'b0, 6'b000100, 1'b1, 6'b000000, 1'b0, 32'h00, 1'b1};

        rst_n           = 1'b0;
        act_in          = '0;
        act_in_row      = '0;
        act_in_vld      = 1'b0;
        inst_in         = '0;
        inst_in_mask    = '0;
        inst_in_vld     = 1'b0;
        act_data_in_req = '0;
        status_sblk     = '0;

        // Reset state
        cyc();
        cyc();
        chk("rst_vld",       act_data_in_vld, 6'b0);
        chk("rst_data",      act_data_in, '0);
        chk("rst_inst_en",   inst_en, 6'b0);
        chk("rst_inst_data", inst_data, '0);
        chk("rst_act_rdy",   act_in_rdy, 1'b1);
        chk("rst_inst_rdy",  inst_in_rdy, 1'b1);
        chk("rst_row_err",   row_err, 1'b0);
        chk("rst_act_cnt",   act_cnt, '0);
        #2 rst_n = 1'b1;
        cyc();

        // Table-driven FIFO vectors
        for (int i = 0; i < N_TBL; i++) begin
            act_in_row      = tbl[i].row;
            act_in          = tbl[i].word;
            act_in_vld      = tbl[i].vld;
            act_data_in_req = tbl[i].req;
            #1;
            chk($sformatf("v%0d_rdy", i), act_in_rdy, tbl[i].exp_rdy);
            cyc();
            act_in_vld      = 1'b0;
            act_data_in_req = '0;
            chk($sformatf("v%0d_vld", i), act_data_in_vld, tbl[i].exp_vld);
            if (tbl[i].chk_head)
                chk($sformatf("v%0d_head2", i), act_data_in[2*32 +: 32], tbl[i].exp_head2);
            chk($sformatf("v%0d_err", i), row_err, tbl[i].exp_err);
            $display("vec %0d row=%0d vld_in=%0b rdy=%0b row_vld=%b head2=%0h err=%0b",
                     i, tbl[i].row, tbl[i].vld, tbl[i].exp_rdy, act_data_in_vld,
                     act_data_in[2*32 +: 32], row_err);
        end
        chk("row3_head_after_pop_empty", act_data_in_vld[3], 1'b0);

        // Stream 10 words to row 0 with req toggling 1,0,1,0...
        begin
            int tx = 0;
            int rx = 0;
            int budget = 0;
            logic tog = 1'b1;
            act_in_row = 3'd0;
            while (rx < 10 && budget < 200) begin
                act_in_vld      = (tx < 10);
                act_in          = 32'hC0DE_0000 + 32'(tx);
                act_data_in_req = {5'b0, tog};
                tog             = ~tog;
                #1;
                if (act_in_vld && act_in_rdy) tx++;
                if (act_data_in_vld[0] && act_data_in_req[0]) begin
                    chk($sformatf("stream_w%0d", rx), act_data_in[31:0], 32'hC0DE_0000 + 32'(rx));
                    $display("stream rx %0d data=%0h", rx, act_data_in[31:0]);
                    rx++;
                end
                cyc();
                budget++;
            end
            act_in_vld      = 1'b0;
            act_data_in_req = '0;
            chk("stream_received", rx, 10);
            chk("stream_sent", tx, 10);
            chk("stream_empty", act_data_in_vld[0], 1'b0);
`ifdef SBLK_FEEDER_CNT_EN
            chk("cnt_row0", act_cnt[15:0], 16'd10);
            chk("cnt_row2", act_cnt[2*16 +: 16], 16'd6);
            chk("cnt_row3", act_cnt[3*16 +: 16], 16'd1);
`else
            chk("cnt_off", act_cnt, '0);
`endif
        end

        // Instruction with a busy row: waits, issues once, then blanks
        inst_in      = 14'h1A5;
        inst_in_mask = 6'b000101;
        inst_in_vld  = 1'b1;
        status_sblk  = 6'b000001;
        #1;
        chk("i1_rdy_accept", inst_in_rdy, 1'b1);
        cyc();
        inst_in_vld = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("i1_wait_en%0d", c), inst_en, 6'b0);
            chk($sformatf("i1_wait_rdy%0d", c), inst_in_rdy, 1'b0);
            cyc();
        end
        status_sblk = 6'b0;
        chk("i1_fall_en", inst_en, 6'b0);
        cyc();
        chk("i1_issue_en", inst_en, 6'b000101);
        chk("i1_data0", islice(inst_data, 0), 14'h1A5);
        chk("i1_data2", islice(inst_data, 2), 14'h1A5);
        chk("i1_data1", islice(inst_data, 1), 14'h0);
        $display("inst 1A5 issued en=%b", inst_en);
        cyc();
        for (int g = 0; g < INST_GAP; g++) begin
            chk($sformatf("i1_blank_en%0d", g), inst_en, 6'b0);
            chk($sformatf("i1_blank_rdy%0d", g), inst_in_rdy, 1'b0);
            cyc();
        end
        chk("i1_rdy_back", inst_in_rdy, 1'b1);

        // Instruction with idle rows: exact latency, unmasked slices hold
        inst_in      = 14'h2AB;
        inst_in_mask = 6'b110000;
        inst_in_vld  = 1'b1;
        cyc();
        inst_in_vld = 1'b0;
        chk("i2_k1_en", inst_en, 6'b0);
        cyc();
        chk("i2_k2_en", inst_en, 6'b110000);
        chk("i2_data4", islice(inst_data, 4), 14'h2AB);
        chk("i2_data5", islice(inst_data, 5), 14'h2AB);
        chk("i2_data0_hold", islice(inst_data, 0), 14'h1A5);
        chk("i2_data2_hold", islice(inst_data, 2), 14'h1A5);
        $display("inst 2AB issued en=%b", inst_en);
        cyc();
        chk("i2_k3_rdy", inst_in_rdy, 1'b0);
        cyc();
        chk("i2_k4_rdy", inst_in_rdy, 1'b0);
        cyc();
        chk("i2_k5_rdy", inst_in_rdy, 1'b1);

        // Zero-mask instruction: accepted, nothing issued
        inst_in      = 14'h3FF;
        inst_in_mask = 6'b0;
        inst_in_vld  = 1'b1;
        #1;
        chk("i3_rdy", inst_in_rdy, 1'b1);
        cyc();
        inst_in_vld = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("i3_en%0d", c), inst_en, 6'b0);
            chk($sformatf("i3_rdy%0d", c), inst_in_rdy, 1'b1);
            cyc();
        end
        chk("i3_data0", islice(inst_data, 0), 14'h1A5);
        $display("inst mask0 done");

        // Reset mid-operation: 3 words buffered on row 1, instruction stuck in WAIT
        act_in_row = 3'd1;
        for (int w = 0; w < 3; w++) begin
            act_in     = 32'h5500 + 32'(w);
            act_in_vld = 1'b1;
            cyc();
        end
        act_in_vld   = 1'b0;
        inst_in      = 14'h0F0;
        inst_in_mask = 6'b000010;
        status_sblk  = 6'b000010;
        inst_in_vld  = 1'b1;
        cyc();
        inst_in_vld = 1'b0;
        cyc();
        chk("pre_rst_vld", act_data_in_vld, 6'b000010);
        chk("pre_rst_rdy", inst_in_rdy, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_vld",       act_data_in_vld, 6'b0);
        chk("arst_data",      act_data_in, '0);
        chk("arst_inst_en",   inst_en, 6'b0);
        chk("arst_inst_data", inst_data, '0);
        chk("arst_inst_rdy",  inst_in_rdy, 1'b1);
        chk("arst_act_rdy",   act_in_rdy, 1'b1);
        chk("arst_row_err",   row_err, 1'b0);
        chk("arst_act_cnt",   act_cnt, '0);
        $display("async reset applied");
        cyc();
        cyc();
        #2 rst_n = 1'b1;
        cyc();
        status_sblk = 6'b0;
        for (int c = 0; c < 6; c++) begin
            chk($sformatf("post_rst_en%0d", c), inst_en, 6'b0);
            cyc();
        end
        chk("post_rst_vld", act_data_in_vld, 6'b0);
        chk("post_rst_irdy", inst_in_rdy, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
